lc3_fetch_unit: RTL
===================

// Module: lc3_fetch_unit
// PURPOSE
//  Instruction fetch stage of the LC3 pipeline; sits directly upstream of the pipeline controller.
//  Owns the PC and issues instruction-memory reads. Holds each fetched word for decode.
//  Reports complete_instr to the controller. Advances PC (sequential or branch/jump target) under controller enables.
// PARAMETERS
//  RESET_PC   16'h3000  PC value loaded on reset
//  MAX_WAIT   15        cycles in REQ without instr_ack before fetch_err sets (1..255)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  enable_fetch     in   1   controller: instruction may be consumed
//  enable_updatePC  in   1   controller: PC may advance
//  br_taken         in   1   controller: select taddr instead of npc
//  taddr            in   16  branch/jump target from execute
//  instr_dout       in   16  instruction-memory read data
//  instr_ack        in   1   instruction-memory data valid, one pulse per read
//  instrmem_rd      out  1   read request, level, registered
//  instr_addr       out  16  read address (= pc)
//  pc               out  16  address of current/held instruction
//  npc              out  16  pc + 1, modulo 2^16
//  instr_out        out  16  held instruction word to decode
//  complete_instr   out  1   instr_out valid (state HOLD)
//  fetch_err        out  1   sticky memory-timeout flag
//  fetch_count      out  16  instructions delivered (macro only, else 0)
//  stall_count      out  16  cycles spent in REQ (macro only, else 0)
// BEHAVIOUR
//  Reset: pc=RESET_PC, npc=RESET_PC+1, instrmem_rd=0, instr_out=0, complete_instr=0, fetch_err=0, wait_cnt=0, state=IDLE.
//  Reset dominates every other input. Reset mid-request drops instrmem_rd on the next edge. A late instr_ack is ignored.
//  States: IDLE, REQ, HOLD. All outputs are registered.
//  IDLE:
//   - instr_ack is ignored.
//   - Moves to REQ unconditionally on the next edge; instrmem_rd=1 the first cycle after reset deasserts.
//  REQ:
//   - instrmem_rd=1, instr_addr=pc; wait_cnt increments each cycle, saturating.
//   - Fetch never waits on enable_fetch to issue a read. The controller stalls while complete_instr=0, so gating here would deadlock.
//   - instr_ack: instr_out<=instr_dout, complete_instr<=1, instrmem_rd<=0, wait_cnt<=0, state<=HOLD.
//   - Latency: ack on cycle N -> complete_instr=1 on cycle N+1.
//   - wait_cnt reaches MAX_WAIT without ack: fetch_err<=1 (sticky until reset). The request stays asserted.
//   - enable_updatePC / br_taken are ignored in REQ.
//  HOLD:
//   - complete_instr=1; instr_out is stable.
//   - Advance when enable_fetch && enable_updatePC are both high:
//     - pc<=br_taken ? taddr : npc; npc<=that value + 1.
//     - complete_instr<=0, state<=REQ; instrmem_rd=1 with the new pc on the next cycle.
//   - One advance per instruction. A single-high enable or both enables low holds all state.
//   - instr_ack in HOLD is ignored; no second outstanding read exists.
//  Arithmetic: 16-bit unsigned; pc=16'hFFFF gives npc=16'h0000 (wrap, no flag). taddr is taken verbatim.
// CONFIGURATION
//  Macro LC3_FETCH_PERF_EN.
//  Defined:
//   - fetch_count increments on each REQ->HOLD transition.
//   - stall_count increments each cycle in REQ.
//   - Both are 16-bit, wrap, and reset to 0.
//  Undefined: both ports are tied to 16'h0000 and no counter flops are built. Function is otherwise identical.
// TESTING
//  1. Reset 3 cycles, release -> cycle+1 instrmem_rd=1, instr_addr=16'h3000, complete_instr=0, fetch_err=0.
//  2. ack 2 cycles after rd with dout=16'h1234; enables high -> instr_out=16'h1234 next cycle; then pc=16'h3001, rd reasserted.
//  3. In HOLD, hold enable_fetch=0 for 5 cycles -> pc, instr_out, complete_instr unchanged, rd=0. Release -> single advance.
//  4. HOLD with br_taken=1, taddr=16'h4000, enables high -> pc=16'h4000, npc=16'h4001, instr_addr=16'h4000.
//  5. Branch to 16'hFFFF, advance sequentially -> npc=16'h0000, next fetch at 16'h0000.
//  6. No ack for MAX_WAIT cycles -> fetch_err=1, rd held; later ack -> HOLD, fetch_err stays 1.
//  7. Reset mid-REQ, ack one cycle later -> ack ignored, restart at RESET_PC. Counters 0 with macro, always 0 without.

Source files
------------

// File: rtl/lc3_fetch_unit.sv
// LC3 instruction fetch stage: owns the PC, issues instruction-memory reads and holds each word for decode.
// Optional performance counters are built only when LC3_FETCH_PERF_EN is defined.
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_fetch_i,
    input  logic        enable_updatepc_i,
    input  logic        br_taken_i,
    input  logic [15:0] taddr_i,
    input  logic [15:0] instr_dout_i,
    input  logic        instr_ack_i,
    output logic        instrmem_rd_o,
    output logic [15:0] instr_addr_o,
    output logic [15:0] pc_o,
    output logic [15:0] npc_o,
    output logic [15:0] instr_out_o,
    output logic        complete_instr_o,
    output logic        fetch_err_o,
    output logic [15:0] fetch_count_o,
    output logic [15:0] stall_count_o
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] instr_q, instr_d;
    logic        rd_q, rd_d;
    logic        cmp_q, cmp_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;
    logic [15:0] target;

    assign target   = br_taken_i ? taddr_i : npc_q;
    assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        cmp_d   = cmp_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                rd_d    = 1'b1;
                wait_d  = 8'd0;
            end
            S_REQ: begin
                // Never gated by enable_fetch: the controller waits on complete_instr.
                rd_d = 1'b1;
                if (instr_ack_i) begin
                    instr_d = instr_dout_i;
                    cmp_d   = 1'b1;
                    rd_d    = 1'b0;
                    wait_d  = 8'd0;
                    state_d = S_HOLD;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc >= MAX_WAIT_C) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (enable_fetch_i && enable_updatepc_i) begin
                    pc_d    = target;
                    npc_d   = target + 16'd1;
                    cmp_d   = 1'b0;
                    rd_d    = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 16'd1;
            instr_q <= 16'h0000;
            rd_q    <= 1'b0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign instrmem_rd_o    = rd_q;
    assign instr_addr_o     = pc_q;
    assign pc_o             = pc_q;
    assign npc_o            = npc_q;
    assign instr_out_o      = instr_q;
    assign complete_instr_o = cmp_q;
    assign fetch_err_o      = err_q;

`ifdef LC3_FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else if (state_q == S_REQ) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
            if (instr_ack_i) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`else
    assign fetch_count_o = 16'h0000;
    assign stall_count_o = 16'h0000;
`endif

endmodule
